// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: collects slot words 0..3 of a frame into shadow
// registers and publishes the whole frame on q0..q3 in one edge.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       slot
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_slot;
  logic [WIDTH-1:0] r_sh0;
  logic [WIDTH-1:0] r_sh1;
  logic [WIDTH-1:0] r_sh2;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;
  logic [WIDTH-1:0] r_q3;
  logic             r_frame_valid;
  logic             r_frame_err;

  // Frame FSM, shadow capture and atomic publication of completed frames
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_slot        <= 2'd0;
      r_sh0         <= {WIDTH{1'b0}};
      r_sh1         <= {WIDTH{1'b0}};
      r_sh2         <= {WIDTH{1'b0}};
      r_q0          <= {WIDTH{1'b0}};
      r_q1          <= {WIDTH{1'b0}};
      r_q2          <= {WIDTH{1'b0}};
      r_q3          <= {WIDTH{1'b0}};
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (din_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (sof) begin
              r_sh0   <= din;
              r_slot  <= 2'd1;
              r_state <= ST_COLLECT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_COLLECT: begin
            if (sof) begin
              // Early start: drop the partial frame and restart at slot 1
              r_frame_err <= 1'b1;
              r_sh0       <= din;
              r_slot      <= 2'd1;
            end else begin
              case (r_slot)
                2'd1: begin
                  r_sh1  <= din;
                  r_slot <= 2'd2;
                end
                2'd2: begin
                  r_sh2  <= din;
                  r_slot <= 2'd3;
                end
                2'd3: begin
                  r_q0          <= r_sh0;
                  r_q1          <= r_sh1;
                  r_q2          <= r_sh2;
                  r_q3          <= din;
                  r_frame_valid <= 1'b1;
                  r_slot        <= 2'd0;
                  r_state       <= ST_IDLE;
                end
                default: begin
                  // Slot 0 is unreachable while collecting; recover to idle
                  r_slot  <= 2'd0;
                  r_state <= ST_IDLE;
                end
              endcase
            end
          end
          default: begin
            r_slot  <= 2'd0;
            r_state <= ST_IDLE;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign q0          = r_q0;
  assign q1          = r_q1;
  assign q2          = r_q2;
  assign q3          = r_q3;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign slot        = r_slot;

endmodule
